vga_sync_gen: RTL and testbench

//   Produces the pixel-coordinate stream that the renderer consumes: x, y and

---
 rtl/vga_sync_gen.sv | 91 +++++++++
 tb/tb_vga_sync_gen.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel-rate enable, horizontal/vertical counters,
// registered sync/display outputs and frame/vblank strobes for game logic.
module vga_sync_gen #(
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0
) (
    input  logic       clk,
    input  logic       reset,
    output logic       pixel_tick,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       display_on,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_start,
    output logic       vblank_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic       SYNC_ACT = (SYNC_POL != 0);

    logic [DIV_W-1:0] div;
    logic [9:0]       x_nxt;
    logic [9:0]       y_nxt;
    logic             hs_nxt;
    logic             vs_nxt;

    // Position of the next pixel; every registered output is decoded from it
    // so all outputs change together with the counters.
    always_comb begin
        x_nxt = x + 10'd1;
        y_nxt = y;
        if (x == H_LAST) begin
            x_nxt = 10'd0;
            if (y == V_LAST) begin
                y_nxt = 10'd0;
            end else begin
                y_nxt = y + 10'd1;
            end
        end
        hs_nxt = (x_nxt >= HS_START) && (x_nxt < HS_END);
        vs_nxt = (y_nxt >= VS_START) && (y_nxt < VS_END);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div          <= '0;
            pixel_tick   <= 1'b0;
            x            <= 10'd0;
            y            <= 10'd0;
            display_on   <= 1'b0;
            hsync        <= ~SYNC_ACT;
            vsync        <= ~SYNC_ACT;
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
        end else begin
            div          <= (div == DIV_LAST) ? '0 : div + DIV_W'(1);
            pixel_tick   <= (div == DIV_LAST);
            frame_start  <= 1'b0;
            vblank_start <= 1'b0;
            if (pixel_tick) begin
                x            <= x_nxt;
                y            <= y_nxt;
                display_on   <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
                hsync        <= hs_nxt ? SYNC_ACT : ~SYNC_ACT;
                vsync        <= vs_nxt ? SYNC_ACT : ~SYNC_ACT;
                frame_start  <= (x_nxt == 10'd0) && (y_nxt == 10'd0);
                vblank_start <= (x_nxt == 10'd0) && (y_nxt == V_VIS);
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a scaled-down timing set
// (32 x 20 total, hsync x=24..29, vsync y=14..15) so whole frames stay short.
module tb_vga_sync_gen;
    logic       clk;
    logic       reset;
    logic       pixel_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       display_on;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       vblank_start;

    int pass_cnt  = 0;
    int total_cnt = 0;

    vga_sync_gen #(
        .CLK_DIV (2),
        .H_ACTIVE(20), .H_FP(4), .H_SYNC(6), .H_BP(2),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(4),
        .SYNC_POL(0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pixel_tick  (pixel_tick),
        .x           (x),
        .y           (y),
        .display_on  (display_on),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .vblank_start(vblank_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] tx;
        logic [9:0] ty;
        logic       de;
        logic       hs;
        logic       vs;
        logic       fs;
        logic       vb;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (x=%0d y=%0d t=%0t)", name, act, exp, x, y, $time);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " pixel_tick"}, 32'(pixel_tick), 0);
        check({tag, " x"}, 32'(x), 0);
        check({tag, " y"}, 32'(y), 0);
        check({tag, " display_on"}, 32'(display_on), 0);
        check({tag, " hsync"}, 32'(hsync), 1);
        check({tag, " vsync"}, 32'(vsync), 1);
        check({tag, " frame_start"}, 32'(frame_start), 0);
        check({tag, " vblank_start"}, 32'(vblank_start), 0);
    endtask

    // Advance clock by clock until the DUT sits at (tx,ty); sample #1 after the edge.
    task automatic wait_pos(input logic [9:0] tx, input logic [9:0] ty, output logic found);
        found = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk);
            #1;
            if (x == tx && y == ty) begin
                found = 1'b1;
                break;
            end
        end
        check($sformatf("reach (%0d,%0d)", tx, ty), 32'(found), 1);
    endtask

    initial begin
        logic found;
        int   ticks, hs_low, de_low, fs_cnt, vb_cnt, vs_low, vs_bad, de_bad;

        vecs[0]  = '{10'd19, 10'd1,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{10'd20, 10'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{10'd23, 10'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{10'd24, 10'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{10'd29, 10'd1,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{10'd30, 10'd1,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{10'd31, 10'd10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{10'd0,  10'd11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{10'd0,  10'd12, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{10'd5,  10'd13, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{10'd0,  10'd14, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{10'd31, 10'd15, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{10'd0,  10'd16, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[13] = '{10'd31, 10'd19, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[14] = '{10'd0,  10'd0,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[15] = '{10'd1,  10'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        // Reset held, then released on a falling edge.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(posedge clk); #1;
        check("edge1 pixel_tick", 32'(pixel_tick), 0);
        check("edge1 x", 32'(x), 0);
        @(posedge clk); #1;
        check("edge2 pixel_tick", 32'(pixel_tick), 1);
        check("edge2 x", 32'(x), 0);
        check("edge2 display_on", 32'(display_on), 0);
        @(posedge clk); #1;
        check("edge3 x", 32'(x), 1);
        check("edge3 y", 32'(y), 0);
        check("edge3 display_on", 32'(display_on), 1);
        check("edge3 frame_start", 32'(frame_start), 0);

        // One full line from (1,0): tick rate, hsync width, blanking width.
        ticks = 0; hs_low = 0; de_low = 0;
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            ticks  += int'(pixel_tick);
            hs_low += int'(!hsync);
            de_low += int'(!display_on);
        end
        check("line ticks", 32'(ticks), 32);
        check("line hsync low clks", 32'(hs_low), 12);
        check("line display_off clks", 32'(de_low), 24);

        for (int i = 0; i < 16; i++) begin
            wait_pos(vecs[i].tx, vecs[i].ty, found);
            check($sformatf("vec%0d display_on", i), 32'(display_on), 32'(vecs[i].de));
            check($sformatf("vec%0d hsync", i), 32'(hsync), 32'(vecs[i].hs));
            check($sformatf("vec%0d vsync", i), 32'(vsync), 32'(vecs[i].vs));
            check($sformatf("vec%0d frame_start", i), 32'(frame_start), 32'(vecs[i].fs));
            check($sformatf("vec%0d vblank_start", i), 32'(vblank_start), 32'(vecs[i].vb));
        end

        // One whole frame starting at (1,0): strobe counts and vertical blanking.
        fs_cnt = 0; vb_cnt = 0; vs_low = 0; vs_bad = 0; de_bad = 0;
        for (int i = 0; i < 1280; i++) begin
            @(posedge clk); #1;
            fs_cnt += int'(frame_start);
            vb_cnt += int'(vblank_start);
            vs_low += int'(!vsync);
            if (!vsync && (y < 10'd14 || y > 10'd15)) vs_bad++;
            if (display_on && (y >= 10'd12 || x >= 10'd20)) de_bad++;
        end
        check("frame frame_start pulses", 32'(fs_cnt), 1);
        check("frame vblank_start pulses", 32'(vb_cnt), 1);
        check("frame vsync low clks", 32'(vs_low), 128);
        check("frame vsync wrong line", 32'(vs_bad), 0);
        check("frame display_on in blank", 32'(de_bad), 0);

        // Strobes last exactly one clock.
        wait_pos(10'd0, 10'd12, found);
        check("vb first clk", 32'(vblank_start), 1);
        @(posedge clk); #1;
        check("vb second clk", 32'(vblank_start), 0);
        check("vb second clk x", 32'(x), 0);
        wait_pos(10'd0, 10'd0, found);
        check("fs first clk", 32'(frame_start), 1);
        check("fs vblank clear", 32'(vblank_start), 0);
        @(posedge clk); #1;
        check("fs second clk", 32'(frame_start), 0);

        // Asynchronous reset mid-frame, then restart from (0,0).
        wait_pos(10'd10, 10'd5, found);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_reset_vals("async reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        fs_cnt = 0;
        repeat (2) begin
            @(posedge clk); #1;
            fs_cnt += int'(frame_start);
        end
        check("restart x before tick", 32'(x), 0);
        @(posedge clk); #1;
        check("restart x", 32'(x), 1);
        check("restart y", 32'(y), 0);
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            fs_cnt += int'(frame_start) + int'(vblank_start);
        end
        check("restart no strobes", 32'(fs_cnt), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
